xor_cipher_engine: RTL
======================

// Module: xor_cipher_engine
// PURPOSE
// - Parametrised successor of the fixed 64-bit/8-bit XOR encryptor. Latches a MSG_W-bit message and KEY_W-bit key,
//   XORs one KEY_W chunk per enabled cycle (LSB chunk first), then presents the result under a valid/ready handshake.
// - Sits between the serial message/key loaders and the ciphertext shift-out logic. XOR is symmetric, so the same block decrypts.
// PARAMETERS
// - MSG_W   64  message/ciphertext width in bits; must be an integer multiple of KEY_W (elaboration error otherwise)
// - KEY_W   8   key width = chunk width in bits
// - NCHUNK  MSG_W/KEY_W (localparam)  chunks per message; CNT_W = $clog2(NCHUNK) (minimum 1)
// PORTS
// - iClk          in   1       clock, rising edge
// - iRst          in   1       reset, asynchronous, active-low
// - iEn           in   1       clock enable for chunk processing; low stalls RUN without losing state
// - iStart        in   1       request: capture iMessage/iKey and begin; honoured only in IDLE or in DONE on the handshake cycle
// - iMessage      in   MSG_W   plaintext (or ciphertext to decrypt)
// - iKey          in   KEY_W   key
// - oBusy         out  1       high in RUN
// - oChunk_idx    out  CNT_W   index of the chunk processed on the next enabled edge
// - oCiphertext   out  MSG_W   result register; stable while oValid
// - oValid        out  1       result available; held until accepted
// - iReady        in   1       consumer accepts the result when oValid && iReady
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; oBusy=0, oValid=0, oChunk_idx=0, oCiphertext=0, internal msg/key regs=0.
// - FSM IDLE -> RUN on iStart: capture iMessage, iKey; clear oCiphertext; oChunk_idx=0.
// - RUN, iEn=1: oCiphertext[idx*KEY_W +: KEY_W] <= msg[idx*KEY_W +: KEY_W] ^ key_cur; idx+1.
//   At idx==NCHUNK-1: write last chunk, idx holds at NCHUNK-1 (no wrap), go DONE.
// - RUN, iEn=0: nothing changes. iStart in RUN is ignored (no re-capture, no error).
// - Latency: oValid rises NCHUNK enabled edges after the iStart capture edge (8 for defaults), plus any stall cycles.
// - DONE: oValid=1, oBusy=0. On oValid && iReady: if iStart same cycle -> capture new operands, go RUN (back-to-back);
//   else go IDLE, oValid=0. oCiphertext keeps its value in IDLE until the next capture clears it.
// - iRst low mid-operation: immediate abort to reset values; partial ciphertext discarded.
// - iEn has no effect in IDLE/DONE; handshake proceeds regardless of iEn.
// CONFIGURATION
// - XOR_KEY_ROTATE_EN defined: key_cur rotates left by 1 bit after each processed chunk (chunk i uses rotl(key,i mod KEY_W)).
// - Not defined: key_cur = captured key for every chunk (classic repeating-key XOR). Rotate logic must be absent, not muxed.
// STRUCTURE
// - Package xor_cipher_pkg: state enum (ST_IDLE, ST_RUN, ST_DONE), default MSG_W/KEY_W constants, rotl function.
// - One sub-module: xor_chunk_unit (combinational KEY_W-bit XOR plus optional rotate of the key); top holds FSM, counter, registers.
// TESTING
// - Basic: msg=64'h0123456789ABCDEF, key=8'hFF, iEn=1, iReady=1 -> oValid after 8 edges, oCiphertext=64'hFEDCBA9876543210, then IDLE.
// - Stall: same operands, iEn low 3 cycles at idx=4 -> oValid after 11 edges, same result; oChunk_idx frozen at 4 during stall.
// - Backpressure/back-to-back: iReady=0 for 5 cycles -> oValid and oCiphertext held; then iReady=1 with iStart, msg=0, key=8'hA5
//   -> returns to RUN same edge, next result 64'hA5A5A5A5A5A5A5A5.
// - Ignore/abort: iStart with new operands at idx=2 -> no effect on result; iRst low at idx=5 -> all outputs 0, state IDLE immediately.
// - Rotate (XOR_KEY_ROTATE_EN): msg=0, key=8'h01 -> 64'h8040201008040201; without macro -> 64'h0101010101010101.
// - Param sweep: MSG_W=32, KEY_W=16, msg=32'hDEADBEEF, key=16'h1234 -> oValid after 2 edges, 32'hCC99ACDB; compare vs reference model.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
// Shared types and helpers for the XOR cipher engine.
// Holds the FSM state encoding, the default message/key widths and a
// generic rotate-left helper used when XOR_KEY_ROTATE_EN is defined.
package xor_cipher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_MSG_W = 64;
  localparam int DEF_KEY_W = 8;

  // Widest key the rotate helper can handle.
  localparam int ROT_MAX_W = 64;

  // Rotate the low 'width' bits of 'value' left by 'amount' positions.
  // Bits at or above 'width' come back as zero.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] value,
                                                input int                   width,
                                                input int                   amount);
    logic [ROT_MAX_W-1:0] result;
    result = '0;
    for (int b = 0; b < ROT_MAX_W; b++) begin
      if (b < width) begin
        result[(b + amount) % width] = value[b];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/xor_cipher_engine_chunk.sv
// xor_chunk_unit: combinational XOR of one KEY_W-wide message chunk with
// the key for that chunk.
// Configuration macro: XOR_KEY_ROTATE_EN. When it is defined, the key is
// rotated left by (chunk index mod KEY_W) before the XOR. When it is not
// defined, the captured key is used unchanged and no rotate hardware exists.
module xor_chunk_unit
  import xor_cipher_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W
`ifdef XOR_KEY_ROTATE_EN
  ,
  parameter int CNT_W = 3
`endif
) (
  input  logic [KEY_W-1:0] i_msgChunk,
  input  logic [KEY_W-1:0] i_key,
`ifdef XOR_KEY_ROTATE_EN
  input  logic [CNT_W-1:0] i_idx,
`endif
  output logic [KEY_W-1:0] o_chunk
);

  logic [KEY_W-1:0] w_keyCur;

`ifdef XOR_KEY_ROTATE_EN
  logic [ROT_MAX_W-1:0] w_rotFull;

  // Chunk i uses the key rotated left by i mod KEY_W.
  always_comb begin
    w_rotFull = rotl(ROT_MAX_W'(i_key), KEY_W, int'(i_idx) % KEY_W);
  end

  assign w_keyCur = w_rotFull[KEY_W-1:0];
`else
  assign w_keyCur = i_key;
`endif

  assign o_chunk = i_msgChunk ^ w_keyCur;

endmodule

// File: rtl/xor_cipher_engine.sv
// xor_cipher_engine: captures a MSG_W-bit message and a KEY_W-bit key, XORs
// one key-wide chunk per enabled cycle (least significant chunk first) and
// then offers the result under a valid/ready handshake. XOR is its own
// inverse, so the same block also decrypts.
// Configuration macro: XOR_KEY_ROTATE_EN (key rotates by one bit per chunk).
module xor_cipher_engine
  import xor_cipher_pkg::*;
#(
  parameter  int MSG_W  = DEF_MSG_W,
  parameter  int KEY_W  = DEF_KEY_W,
  localparam int NCHUNK = MSG_W / KEY_W,
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iStart,
  input  logic [MSG_W-1:0] iMessage,
  input  logic [KEY_W-1:0] iKey,
  output logic             oBusy,
  output logic [CNT_W-1:0] oChunk_idx,
  output logic [MSG_W-1:0] oCiphertext,
  output logic             oValid,
  input  logic             iReady
);

  if ((MSG_W % KEY_W) != 0 || MSG_W < KEY_W) begin : g_badWidth
    $error("xor_cipher_engine: MSG_W must be a non-zero multiple of KEY_W");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic             w_capture;
  logic             w_process;
  logic             w_lastChunk;
  logic [MSG_W-1:0] r_msg;
  logic [KEY_W-1:0] r_key;
  logic [CNT_W-1:0] r_idx;
  logic [MSG_W-1:0] r_cipher;
  logic [MSG_W-1:0] w_cipherNext;
  logic [KEY_W-1:0] w_msgChunk;
  logic [KEY_W-1:0] w_chunkOut;

  assign w_lastChunk = (r_idx == CNT_W'(NCHUNK - 1));

  // State register; reset aborts any operation in progress.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the capture/process strobes for the datapath.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_process   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_capture   = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (iEn) begin
          w_process = 1'b1;
          if (w_lastChunk) begin
            w_nextState = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (iReady) begin
          if (iStart) begin
            w_capture   = 1'b1;
            w_nextState = ST_RUN;
          end else begin
            w_nextState = ST_IDLE;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Select the current message chunk and merge the XORed chunk into the result.
  always_comb begin
    w_msgChunk   = '0;
    w_cipherNext = r_cipher;
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_idx == CNT_W'(c)) begin
        w_msgChunk                     = r_msg[c*KEY_W +: KEY_W];
        w_cipherNext[c*KEY_W +: KEY_W] = w_chunkOut;
      end
    end
  end

  xor_chunk_unit #(
    .KEY_W(KEY_W)
`ifdef XOR_KEY_ROTATE_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_chunk (
    .i_msgChunk(w_msgChunk),
    .i_key     (r_key),
`ifdef XOR_KEY_ROTATE_EN
    .i_idx     (r_idx),
`endif
    .o_chunk   (w_chunkOut)
  );

  // Operand capture, chunk counter and result register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_msg    <= '0;
      r_key    <= '0;
      r_idx    <= '0;
      r_cipher <= '0;
    end else if (w_capture) begin
      r_msg    <= iMessage;
      r_key    <= iKey;
      r_idx    <= '0;
      r_cipher <= '0;
    end else if (w_process) begin
      r_cipher <= w_cipherNext;
      if (!w_lastChunk) begin
        r_idx <= r_idx + CNT_W'(1);
      end
    end
  end

  assign oBusy       = (r_state == ST_RUN);
  assign oValid      = (r_state == ST_DONE);
  assign oChunk_idx  = r_idx;
  assign oCiphertext = r_cipher;

endmodule
